// File: rtl/axi_txn_throttle.sv
// ============================================================================
// axi_txn_throttle: caps outstanding AXI4 reads/writes and holds W until its AW
// has been forwarded. Optional stall counters: AXI_TXN_THROTTLE_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

package axi_txn_throttle_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_txn_throttle #(
  parameter int unsigned MaxWrTxns = 8,
  parameter int unsigned MaxRdTxns = 8,
  parameter type axi_req_t  = axi_txn_throttle_pkg::axi_req_t,
  parameter type axi_resp_t = axi_txn_throttle_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
`ifdef AXI_TXN_THROTTLE_STATS_EN
  ,
  output logic [31:0] stall_aw_o,
  output logic [31:0] stall_ar_o
`endif
);

  localparam int unsigned WR_CNT_W = $clog2(MaxWrTxns + 1);
  localparam int unsigned RD_CNT_W = $clog2(MaxRdTxns + 1);
  localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(MaxWrTxns);
  localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(MaxRdTxns);

  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [WR_CNT_W-1:0] w_pend_q, w_pend_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic aw_open, ar_open, w_open;
  logic aw_fwd, ar_fwd, w_last_fwd, b_fwd, r_last_fwd;

  // Gating looks only at registered counts, so no ready-to-valid loop is formed.
  assign aw_open = (wr_cnt_q < WR_MAX);
  assign ar_open = (rd_cnt_q < RD_MAX);
  assign w_open  = (w_pend_q != '0);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_open;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_open;
    mst_req_o.w_valid  = slv_req_i.w_valid && w_open;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready && w_open;
  end

  assign aw_fwd     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign ar_fwd     = mst_req_o.ar_valid && mst_resp_i.ar_ready;
  assign w_last_fwd = mst_req_o.w_valid && mst_resp_i.w_ready && slv_req_i.w.last;
  assign b_fwd      = mst_resp_i.b_valid && slv_req_i.b_ready;
  assign r_last_fwd = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

  // Decrements saturate at zero so a stray response cannot wrap a counter.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_fwd && !b_fwd) begin
      wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
    end else if (b_fwd && !aw_fwd && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WR_CNT_W'(1);
    end

    w_pend_d = w_pend_q;
    if (aw_fwd && !w_last_fwd) begin
      w_pend_d = w_pend_q + WR_CNT_W'(1);
    end else if (w_last_fwd && !aw_fwd && (w_pend_q != '0)) begin
      w_pend_d = w_pend_q - WR_CNT_W'(1);
    end

    rd_cnt_d = rd_cnt_q;
    if (ar_fwd && !r_last_fwd) begin
      rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    end else if (r_last_fwd && !ar_fwd && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      w_pend_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      w_pend_q <= w_pend_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

`ifdef AXI_TXN_THROTTLE_STATS_EN
  logic [31:0] stall_aw_q, stall_aw_d;
  logic [31:0] stall_ar_q, stall_ar_d;

  always_comb begin
    stall_aw_d = stall_aw_q;
    stall_ar_d = stall_ar_q;
    if (slv_req_i.aw_valid && (wr_cnt_q == WR_MAX)) begin
      stall_aw_d = stall_aw_q + 32'd1;
    end
    if (slv_req_i.ar_valid && (rd_cnt_q == RD_MAX)) begin
      stall_ar_d = stall_ar_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_aw_q <= '0;
      stall_ar_q <= '0;
    end else begin
      stall_aw_q <= stall_aw_d;
      stall_ar_q <= stall_ar_d;
    end
  end

  assign stall_aw_o = stall_aw_q;
  assign stall_ar_o = stall_ar_q;
`endif

`ifndef SYNTHESIS
  a_b_needs_outstanding_write : assert property (
    @(posedge clk_i) disable iff (!rst_ni) b_fwd |-> (wr_cnt_q != '0));
  a_r_last_needs_outstanding_read : assert property (
    @(posedge clk_i) disable iff (!rst_ni) r_last_fwd |-> (rd_cnt_q != '0));
`endif

endmodule

`default_nettype wire
